tx_link_arbiter: RTL and testbench
==================================

Name: tx_link_arbiter

Overview:
- Schedules flits from NUM_VC per-virtual-channel requesters onto the single outgoing PHY transmit path that feeds the TX PHY manager / 8b10b encoder.
- Round-robin arbitration between VCs, gated by per-VC credit counters.
- Packet lock keeps a multi-flit packet contiguous on the link.
- One-entry registered output stage with valid/ready handshake toward the PHY.

Parameters:
- NUM_VC, 4, number of virtual channels / requesters (>=2).
- FLIT_W, 64, flit width in bits (vc, id, req, payload packed).
- MAX_CREDITS, 8, per-VC credit count at reset; saturation limit.
- CRED_W, $clog2(MAX_CREDITS+1), credit counter width (derived).

Ports:
- clk  in  1  clock
- n_rst  in  1  reset, asynchronous, active-low
- req_valid  in  NUM_VC  per-VC flit available
- req_last  in  NUM_VC  per-VC flit is last of packet
- req_flit  in  NUM_VC*FLIT_W  per-VC flit; VC i occupies bits [i*FLIT_W +: FLIT_W]
- req_ready  out  NUM_VC  one-hot flit-accepted strobe
- out_valid  out  1  output register holds a flit
- out_flit  out  FLIT_W  flit to PHY manager
- out_vc  out  $clog2(NUM_VC)  VC of out_flit
- out_ready  in  1  PHY accepts flit (PHY data_ready)
- credit_ret_valid  in  1  downstream returned one credit
- credit_ret_vc  in  $clog2(NUM_VC)  VC of returned credit
- credits  out  NUM_VC*CRED_W  current per-VC credit counts

Behaviour:
- Reset values:
  - out_valid=0, out_flit=0, out_vc=0, req_ready=0.
  - All credits=MAX_CREDITS.
  - rr_ptr=0, state=IDLE.
- load_en = !out_valid || out_ready. Output register loads only when load_en=1; otherwise out_flit/out_vc hold stable.
- Eligible VC i: req_valid[i] && credit[i]!=0.
- Arbitration is combinational; req_ready is combinational and asserted only when load_en=1.
  - At most one req_ready bit high per cycle.
  - Requester treats req_valid && req_ready as transfer.
- FSM states: IDLE, LOCKED(lock_vc).
  - IDLE, load_en, any eligible VC:
    - Grant the first eligible VC scanning rr_ptr, rr_ptr+1, ... mod NUM_VC.
    - Capture the flit; out_valid=1 next cycle.
    - Decrement that VC's credit.
    - rr_ptr <= winner+1 mod NUM_VC.
    - If !req_last[winner], go to LOCKED with lock_vc=winner.
  - IDLE, no eligible VC: no grant. If out_ready=1, out_valid falls to 0.
  - LOCKED: only lock_vc may be granted, subject to the same eligibility.
    - Other VCs are blocked even if eligible.
    - Grant with req_last[lock_vc]=1 returns to IDLE.
    - rr_ptr is not modified while LOCKED.
- Latency: granted flit appears on out_flit the cycle after req_ready; out_valid persists until out_ready.
- Throughput: one flit per cycle when out_ready is held high and a VC is eligible.
- Credit updates:
  - Consume and return on the same VC in the same cycle: net 0.
  - Return when credit==MAX_CREDITS: saturates (stays MAX).
  - Consume never occurs at credit 0, because a VC at 0 is ineligible.
- Credit stall inside a packet: LOCKED VC at 0 credits stalls the link (no other VC granted) until a credit returns.
- Reset asserted mid-packet: everything returns to reset values immediately; any flit in the output register is dropped.

Optional Feature:
- Macro: TX_LINK_ARB_STATS_EN.
- Defined:
  - Adds output stall_cnt (16 bits, reset 0); increments each cycle out_valid && !out_ready, saturating at 16'hFFFF.
  - Adds output pkt_cnt (16 bits, reset 0); increments on each granted flit with req_last=1; wraps.
- Undefined: neither port nor counter exists; behaviour otherwise identical.

Test Plan:
- Reset, then idle with all req_valid=0 -> out_valid=0, req_ready=0, every credit=8.
- All 4 VCs valid, single-flit packets (req_last=1), out_ready=1 -> grants in order VC0,1,2,3,0; out_vc follows one cycle later; each credit decrements by 1 per grant.
- VC1 sends 3-flit packet while VC2 is valid -> VC1 granted 3 consecutive cycles, then VC2 granted; rr_ptr=2 after the VC1 header grant.
- VC0 drains 8 flits with no credit return -> VC0 ineligible at credit 0. Then credit_ret_vc=0 pulse -> VC0 granted again next arbitration.
- out_ready=0 for 5 cycles with out_valid=1 -> out_flit stable, req_ready=0 throughout. With TX_LINK_ARB_STATS_EN, stall_cnt=5.
- Same-cycle grant on VC3 and credit return on VC3 at credit 4 -> credit stays 4. Return on a VC already at 8 -> stays 8.

Source files
------------

// File: rtl/tx_link_arbiter.sv
// Round-robin, credit-gated flit arbiter with packet lock and a one-entry output register.
// Optional statistics counters are built when TX_LINK_ARB_STATS_EN is defined.
module tx_link_arbiter #(
    parameter int NUM_VC      = 4,
    parameter int FLIT_W      = 64,
    parameter int MAX_CREDITS = 8,
    parameter int CRED_W      = $clog2(MAX_CREDITS + 1)
) (
    input  logic                       clk,
    input  logic                       n_rst,
    input  logic [NUM_VC-1:0]          req_valid,
    input  logic [NUM_VC-1:0]          req_last,
    input  logic [NUM_VC*FLIT_W-1:0]   req_flit,
    output logic [NUM_VC-1:0]          req_ready,
    output logic                       out_valid,
    output logic [FLIT_W-1:0]          out_flit,
    output logic [$clog2(NUM_VC)-1:0]  out_vc,
    input  logic                       out_ready,
    input  logic                       credit_ret_valid,
    input  logic [$clog2(NUM_VC)-1:0]  credit_ret_vc,
`ifdef TX_LINK_ARB_STATS_EN
    output logic [15:0]                stall_cnt,
    output logic [15:0]                pkt_cnt,
`endif
    output logic [NUM_VC*CRED_W-1:0]   credits
);

    localparam int VC_W = $clog2(NUM_VC);

    typedef enum logic {ST_IDLE, ST_LOCKED} state_t;

    state_t             r_state;
    logic [VC_W-1:0]    r_lock_vc;
    logic [VC_W-1:0]    r_rr_ptr;
    logic               r_out_valid;
    logic [FLIT_W-1:0]  r_out_flit;
    logic [VC_W-1:0]    r_out_vc;
    logic [CRED_W-1:0]  r_credit [NUM_VC];

    logic               w_load_en;
    logic [NUM_VC-1:0]  w_elig;
    logic               w_grant_vld;
    logic [VC_W-1:0]    w_winner;
    logic [VC_W-1:0]    w_next_ptr;
    logic [FLIT_W-1:0]  w_flit;
    logic [NUM_VC-1:0]  w_dec;
    logic [NUM_VC-1:0]  w_inc;
    int                 w_idx;

    assign w_load_en = !r_out_valid || out_ready;

    // NOTE: combinational blocks use blocking '=' with a default for every variable first, so no latch is inferred.
    always_comb begin
        w_elig      = '0;
        w_grant_vld = 1'b0;
        w_winner    = '0;
        w_idx       = 0;
        for (int i = 0; i < NUM_VC; i++)
            w_elig[i] = req_valid[i] && (r_credit[i] != '0);
        if (w_load_en) begin
            if (r_state == ST_LOCKED) begin
                if (w_elig[r_lock_vc]) begin
                    w_grant_vld = 1'b1;
                    w_winner    = r_lock_vc;
                end
            end else begin
                for (int k = 0; k < NUM_VC; k++) begin
                    w_idx = (int'(r_rr_ptr) + k) % NUM_VC;
                    if (!w_grant_vld && w_elig[w_idx]) begin
                        w_grant_vld = 1'b1;
                        w_winner    = VC_W'(w_idx);
                    end
                end
            end
        end
    end

    assign w_flit     = req_flit[w_winner*FLIT_W +: FLIT_W];
    assign w_next_ptr = (w_winner == VC_W'(NUM_VC - 1)) ? '0 : w_winner + 1'b1;

    always_comb begin
        req_ready = '0;
        w_dec     = '0;
        w_inc     = '0;
        if (w_grant_vld)
            req_ready[w_winner] = 1'b1;
        for (int i = 0; i < NUM_VC; i++) begin
            w_dec[i] = w_grant_vld && (w_winner == VC_W'(i));
            w_inc[i] = credit_ret_valid && (credit_ret_vc == VC_W'(i));
        end
    end

    // NOTE: the credit array is a handful of flops, not a RAM, so every entry takes the async reset.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            for (int i = 0; i < NUM_VC; i++)
                r_credit[i] <= CRED_W'(MAX_CREDITS);
        end else begin
            for (int i = 0; i < NUM_VC; i++) begin
                if (w_dec[i] && !w_inc[i])
                    r_credit[i] <= r_credit[i] - 1'b1;
                else if (w_inc[i] && !w_dec[i] && (r_credit[i] != CRED_W'(MAX_CREDITS)))
                    r_credit[i] <= r_credit[i] + 1'b1;
            end
        end
    end

    // Output stage holds its flit whenever the PHY back-pressures; the FSM only moves on a grant.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_state     <= ST_IDLE;
            r_lock_vc   <= '0;
            r_rr_ptr    <= '0;
            r_out_valid <= 1'b0;
            r_out_flit  <= '0;
            r_out_vc    <= '0;
        end else begin
            if (w_load_en) begin
                r_out_valid <= w_grant_vld;
                if (w_grant_vld) begin
                    r_out_flit <= w_flit;
                    r_out_vc   <= w_winner;
                end
            end
            case (r_state)
                ST_IDLE: begin
                    if (w_grant_vld) begin
                        r_rr_ptr <= w_next_ptr;
                        if (!req_last[w_winner]) begin
                            r_state   <= ST_LOCKED;
                            r_lock_vc <= w_winner;
                        end
                    end
                end
                ST_LOCKED: begin
                    if (w_grant_vld && req_last[w_winner])
                        r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign out_valid = r_out_valid;
    assign out_flit  = r_out_flit;
    assign out_vc    = r_out_vc;

    always_comb begin
        credits = '0;
        for (int i = 0; i < NUM_VC; i++)
            credits[i*CRED_W +: CRED_W] = r_credit[i];
    end

`ifdef TX_LINK_ARB_STATS_EN
    logic [15:0] r_stall_cnt;
    logic [15:0] r_pkt_cnt;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_stall_cnt <= '0;
            r_pkt_cnt   <= '0;
        end else begin
            if (r_out_valid && !out_ready && (r_stall_cnt != 16'hFFFF))
                r_stall_cnt <= r_stall_cnt + 1'b1;
            if (w_grant_vld && req_last[w_winner])
                r_pkt_cnt <= r_pkt_cnt + 1'b1;
        end
    end

    assign stall_cnt = r_stall_cnt;
    assign pkt_cnt   = r_pkt_cnt;
`else
    // Statistics counters are not built in this configuration.
`endif

endmodule

// File: tb/tb_tx_link_arbiter.sv
// Directed bench for tx_link_arbiter: round-robin order, packet lock, credit exhaustion/return,
// output back-pressure, credit saturation and mid-packet reset.
module tb_tx_link_arbiter;

    localparam int NUM_VC = 4;
    localparam int FLIT_W = 64;
    localparam int CRED_W = 4;

    logic                      clk = 1'b0;
    logic                      n_rst;
    logic [NUM_VC-1:0]         req_valid;
    logic [NUM_VC-1:0]         req_last;
    logic [NUM_VC*FLIT_W-1:0]  req_flit;
    logic [NUM_VC-1:0]         req_ready;
    logic                      out_valid;
    logic [FLIT_W-1:0]         out_flit;
    logic [1:0]                out_vc;
    logic                      out_ready;
    logic                      credit_ret_valid;
    logic [1:0]                credit_ret_vc;
    logic [NUM_VC*CRED_W-1:0]  credits;
`ifdef TX_LINK_ARB_STATS_EN
    logic [15:0]               stall_cnt;
    logic [15:0]               pkt_cnt;
`endif

    int n_checks = 0;
    int n_errors = 0;
    int exp_cred [NUM_VC];

    tx_link_arbiter #(
        .NUM_VC(NUM_VC), .FLIT_W(FLIT_W), .MAX_CREDITS(8)
    ) dut (
        .clk(clk),
        .n_rst(n_rst),
        .req_valid(req_valid),
        .req_last(req_last),
        .req_flit(req_flit),
        .req_ready(req_ready),
        .out_valid(out_valid),
        .out_flit(out_flit),
        .out_vc(out_vc),
        .out_ready(out_ready),
        .credit_ret_valid(credit_ret_valid),
        .credit_ret_vc(credit_ret_vc),
`ifdef TX_LINK_ARB_STATS_EN
        .stall_cnt(stall_cnt),
        .pkt_cnt(pkt_cnt),
`endif
        .credits(credits)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_flit(input int vc, input logic [63:0] v);
        req_flit[vc*FLIT_W +: FLIT_W] = v;
    endtask

    function automatic logic [15:0] pack_exp();
        logic [15:0] p;
        for (int i = 0; i < NUM_VC; i++)
            p[i*CRED_W +: CRED_W] = 4'(exp_cred[i]);
        return p;
    endfunction

    initial begin
        n_rst = 1'b0; req_valid = '0; req_last = '0; req_flit = '0;
        out_ready = 1'b0; credit_ret_valid = 1'b0; credit_ret_vc = '0;
        for (int i = 0; i < NUM_VC; i++) exp_cred[i] = 8;

        // Reset state
        repeat (2) tick();
        #1;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_req_ready", 64'(req_ready), 64'd0);
        check("rst_out_flit", out_flit, 64'd0);
        check("rst_out_vc", 64'(out_vc), 64'd0);
        check("rst_credits", 64'(credits), 64'h8888);
`ifdef TX_LINK_ARB_STATS_EN
        check("rst_stall_cnt", 64'(stall_cnt), 64'd0);
        check("rst_pkt_cnt", 64'(pkt_cnt), 64'd0);
`endif
        n_rst = 1'b1; out_ready = 1'b1;
        tick(); #1;
        check("idle_out_valid", 64'(out_valid), 64'd0);
        check("idle_req_ready", 64'(req_ready), 64'd0);
        check("idle_credits", 64'(credits), 64'h8888);
        tick();

        // All VCs, single-flit packets: VC0,1,2,3,0
        req_valid = 4'hF; req_last = 4'hF;
        for (int i = 0; i < NUM_VC; i++) set_flit(i, 64'h1000 + 64'(i));
        for (int g = 0; g < 5; g++) begin
            #1;
            check("rr_grant", 64'(req_ready), 64'(4'b0001 << (g % 4)));
            check("rr_credits", 64'(credits), 64'(pack_exp()));
            if (g > 0) begin
                check("rr_out_vc", 64'(out_vc), 64'((g - 1) % 4));
                check("rr_out_flit", out_flit, 64'h1000 + 64'((g - 1) % 4));
            end
            tick();
            exp_cred[g % 4]--;
        end
        req_valid = '0;
        #1;
        check("rr_tail_ready", 64'(req_ready), 64'd0);
        check("rr_tail_vc", 64'(out_vc), 64'd0);
        check("rr_tail_credits", 64'(credits), 64'h7776);
        tick(); #1;
        check("rr_drain_valid", 64'(out_valid), 64'd0);
        tick();

        // VC1 3-flit packet with VC2 waiting (rr_ptr=1)
        req_valid = 4'b0110; req_last = 4'b0100;
        set_flit(1, 64'h2100); set_flit(2, 64'h2200);
        #1;
        check("lock_hdr_grant", 64'(req_ready), 64'b0010);
        tick();
        set_flit(1, 64'h2101);
        #1;
        check("lock_body_grant", 64'(req_ready), 64'b0010);
        check("lock_hdr_flit", out_flit, 64'h2100);
        check("lock_hdr_vc", 64'(out_vc), 64'd1);
        tick();
        set_flit(1, 64'h2102); req_last = 4'b0110;
        #1;
        check("lock_tail_grant", 64'(req_ready), 64'b0010);
        check("lock_body_flit", out_flit, 64'h2101);
        tick(); #1;
        check("after_lock_vc2", 64'(req_ready), 64'b0100);
        check("lock_tail_flit", out_flit, 64'h2102);
        tick();
        req_valid = '0;
        #1;
        check("vc2_out_vc", 64'(out_vc), 64'd2);
        check("vc2_out_flit", out_flit, 64'h2200);
        check("lock_credits", 64'(credits), 64'h7646);
        tick();

        // Drain VC0 (credit 6) to zero
        req_valid = 4'b0001; req_last = 4'b0001;
        for (int k = 0; k < 6; k++) begin
            set_flit(0, 64'h3000 + 64'(k));
            #1;
            check("drain_grant", 64'(req_ready), 64'b0001);
            tick();
        end
        #1;
        check("vc0_no_credit", 64'(req_ready), 64'd0);
        check("drain_credits", 64'(credits), 64'h7640);
        check("drain_last_flit", out_flit, 64'h3005);
        tick(); #1;
        check("drain_valid_fall", 64'(out_valid), 64'd0);
        credit_ret_valid = 1'b1; credit_ret_vc = 2'd0;
        #1;
        check("ret_same_cycle_block", 64'(req_ready), 64'd0);
        tick();
        credit_ret_valid = 1'b0; req_last = 4'b0000; set_flit(0, 64'h3100);
        #1;
        check("vc0_regrant", 64'(req_ready), 64'b0001);
        check("ret_credits", 64'(credits), 64'h7641);
        tick();

        // Locked VC0 at zero credits stalls the link despite eligible VC2
        req_valid = 4'b0101; req_last = 4'b0101; set_flit(2, 64'h3200);
        #1;
        check("lock_stall_1", 64'(req_ready), 64'd0);
        tick(); #1;
        check("lock_stall_2", 64'(req_ready), 64'd0);
        check("lock_stall_flit", out_flit, 64'h3100);
        tick();
        credit_ret_valid = 1'b1; credit_ret_vc = 2'd0;
        #1;
        check("lock_stall_3", 64'(req_ready), 64'd0);
        tick();
        credit_ret_valid = 1'b0; set_flit(0, 64'h3101);
        #1;
        check("lock_resume_tail", 64'(req_ready), 64'b0001);
        tick(); #1;
        check("unlock_vc2", 64'(req_ready), 64'b0100);
        check("unlock_tail_flit", out_flit, 64'h3101);
        tick();
        req_valid = '0;
        #1;
        check("stall_phase_credits", 64'(credits), 64'h7540);
        check("unlock_vc2_flit", out_flit, 64'h3200);
        tick();

        // PHY back-pressure for 5 cycles
        req_valid = 4'b1000; req_last = 4'b1000; set_flit(3, 64'h4300);
        #1;
        check("bp_first_grant", 64'(req_ready), 64'b1000);
        tick();
        out_ready = 1'b0; set_flit(3, 64'h4301);
        for (int k = 0; k < 5; k++) begin
            #1;
            check("bp_ready_low", 64'(req_ready), 64'd0);
            check("bp_flit_stable", out_flit, 64'h4300);
            check("bp_valid_held", 64'(out_valid), 64'd1);
            tick();
        end
        out_ready = 1'b1;
        #1;
`ifdef TX_LINK_ARB_STATS_EN
        check("stall_cnt", 64'(stall_cnt), 64'd5);
        check("pkt_cnt", 64'(pkt_cnt), 64'd16);
`endif
        check("bp_release_grant", 64'(req_ready), 64'b1000);
        check("bp_release_flit", out_flit, 64'h4300);
        tick();

        // Consume+return on VC3 at credit 4 nets zero
        set_flit(3, 64'h4302);
        #1;
        check("vc3_grant_a", 64'(req_ready), 64'b1000);
        check("bp_next_flit", out_flit, 64'h4301);
        check("vc3_cred5", 64'(credits), 64'h5540);
        tick();
        credit_ret_valid = 1'b1; credit_ret_vc = 2'd3; set_flit(3, 64'h4303);
        #1;
        check("vc3_grant_b", 64'(req_ready), 64'b1000);
        check("vc3_cred4", 64'(credits), 64'h4540);
        tick();
        credit_ret_valid = 1'b0; req_valid = '0;
        #1;
        check("net_zero_credit", 64'(credits), 64'h4540);
        check("net_zero_flit", out_flit, 64'h4303);
        tick();

        // Reset mid-packet (VC2 locked, flit in output register)
        req_valid = 4'b0100; req_last = 4'b0000; set_flit(2, 64'h6200);
        #1;
        check("pre_rst_grant", 64'(req_ready), 64'b0100);
        tick();
        n_rst = 1'b0; req_valid = '0;
        #1;
        check("mid_rst_valid", 64'(out_valid), 64'd0);
        check("mid_rst_flit", out_flit, 64'd0);
        check("mid_rst_ready", 64'(req_ready), 64'd0);
        check("mid_rst_credits", 64'(credits), 64'h8888);
`ifdef TX_LINK_ARB_STATS_EN
        check("mid_rst_stall_cnt", 64'(stall_cnt), 64'd0);
`endif
        tick();
        n_rst = 1'b1;
        req_valid = 4'b0101; req_last = 4'b0101;
        set_flit(0, 64'h6000); set_flit(2, 64'h6201);
        credit_ret_valid = 1'b1; credit_ret_vc = 2'd1;
        #1;
        check("post_rst_rr0", 64'(req_ready), 64'b0001);
        tick();
        credit_ret_valid = 1'b0; req_valid = '0;
        #1;
        check("post_rst_vc", 64'(out_vc), 64'd0);
        check("post_rst_flit", out_flit, 64'h6000);
        check("post_rst_valid", 64'(out_valid), 64'd1);
        check("sat_credits", 64'(credits), 64'h8887);
        tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
